// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// riscv_pkg : shared rv32i types and constants
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ll_wb_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
//------------------------------------------------------------------------------
// wb_fifo : synchronous FIFO with registered full flag, sync active-low reset
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     pop_data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T               mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q;
    logic           do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/rf_wp_arbiter.sv
//------------------------------------------------------------------------------
// rf_wp_arbiter : RF write-port arbiter, long-latency FIFO and pending scoreboard
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rf_wp_arbiter #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            LLIssueE,
    input  logic [4:0]      LLRdE,
    input  logic            LLValid,
    input  logic [4:0]      LLRd,
    input  logic [XLEN-1:0] LLData,
    output logic            LLReady,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            LLBusyD,
    output logic            WbStallReq,
    output logic            RFWE,
    output logic [4:0]      RFA3,
    output logic [XLEN-1:0] RFWD
);

    import riscv_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          active_q;

    ll_wb_t        ll_in, head;
    logic          fifo_full, fifo_empty, push;
    logic          pipe_wr, stall, head_gnt, pipe_gnt, issue_vld;
    logic [31:0]   set_mask, clr_mask, busy_mask;

    assign stall      = (starve_q == STARVE_LIM);
    assign WbStallReq = stall;

    assign pipe_wr   = RegWriteW && (RdW != REG_X0);
    assign head_gnt  = rst && !fifo_empty && (stall || !pipe_wr);
    assign pipe_gnt  = rst && pipe_wr && !stall;
    assign issue_vld = LLIssueE && (LLRdE != REG_X0);

    // active_q holds LLReady low for the first cycle after reset release.
    assign LLReady = rst && active_q && !fifo_full;
    assign push    = LLValid && LLReady && (LLRd != REG_X0);

    assign ll_in.rd   = LLRd;
    assign ll_in.data = LLData;

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (ll_wb_t)
    ) u_wb_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (ll_in),
        .pop_i       (head_gnt),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        RFWE = 1'b0;
        RFA3 = REG_X0;
        RFWD = '0;
        if (head_gnt) begin
            RFWE = 1'b1;
            RFA3 = head.rd;
            RFWD = head.data;
        end else if (pipe_gnt) begin
            RFWE = 1'b1;
            RFA3 = RdW;
            RFWD = ResultW;
        end
    end

    always_comb begin
        set_mask  = (rst && issue_vld) ? (32'd1 << LLRdE) : 32'd0;
        clr_mask  = head_gnt ? (32'd1 << head.rd) : 32'd0;
        pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
        busy_mask = (pending_q | (issue_vld ? (32'd1 << LLRdE) : 32'd0)) & ~32'd1;
        LLBusyD   = rst && (busy_mask[Rs1D] || busy_mask[Rs2D] || busy_mask[RdD]);
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || head_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q  <= '0;
            pending_q <= '0;
            active_q  <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            pending_q <= pending_d;
            active_q  <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_wp_arbiter.sv
//------------------------------------------------------------------------------
// tb_rf_wp_arbiter : directed self-checking bench for rf_wp_arbiter
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_wp_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            LLIssueE;
    logic [4:0]      LLRdE;
    logic            LLValid;
    logic [4:0]      LLRd;
    logic [XLEN-1:0] LLData;
    logic            LLReady;
    logic [4:0]      Rs1D, Rs2D, RdD;
    logic            LLBusyD;
    logic            WbStallReq;
    logic            RFWE;
    logic [4:0]      RFA3;
    logic [XLEN-1:0] RFWD;

    int vectors     = 0;
    int miscompares = 0;

    rf_wp_arbiter #(
        .XLEN       (XLEN),
        .DEPTH      (2),
        .STARVE_MAX (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .LLIssueE   (LLIssueE),
        .LLRdE      (LLRdE),
        .LLValid    (LLValid),
        .LLRd       (LLRd),
        .LLData     (LLData),
        .LLReady    (LLReady),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .LLBusyD    (LLBusyD),
        .WbStallReq (WbStallReq),
        .RFWE       (RFWE),
        .RFA3       (RFA3),
        .RFWD       (RFWD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs are then driven and
    // outputs sampled 4ns later, well before the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        rst = 1'b0;
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hAAAA_AAAA;
        LLIssueE = 1'b1; LLRdE = 5'd7;
        LLValid = 1'b1; LLRd = 5'd7; LLData = 32'h1111_1111;
        Rs1D = 5'd7; Rs2D = 5'd0; RdD = 5'd0;

        // Reset held with live inputs
        tick(); tick(); settle();
        chk("rst_rfwe",    32'(RFWE),       32'd0);
        chk("rst_ready",   32'(LLReady),    32'd0);
        chk("rst_busy",    32'(LLBusyD),    32'd0);
        chk("rst_stall",   32'(WbStallReq), 32'd0);
        chk("rst_rfa3",    32'(RFA3),       32'd0);
        chk("rst_rfwd",    RFWD,            32'd0);

        tick();
        rst = 1'b1;
        RegWriteW = 1'b0; LLIssueE = 1'b0; LLValid = 1'b0;
        tick(); settle();
        chk("rel_ready",   32'(LLReady),    32'd1);
        chk("rel_no_wr",   32'(RFWE),       32'd0);
        chk("rel_no_pend", 32'(LLBusyD),    32'd0);

        // Pipeline pass-through
        tick();
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEAD_BEEF;
        settle();
        chk("pipe_we",     32'(RFWE),       32'd1);
        chk("pipe_a3",     32'(RFA3),       32'd5);
        chk("pipe_wd",     RFWD,            32'hDEAD_BEEF);

        // Long-latency round trip on x7
        tick();
        RegWriteW = 1'b0;
        LLIssueE = 1'b1; LLRdE = 5'd7; Rs1D = 5'd7;
        settle();
        chk("ll_busy_iss", 32'(LLBusyD),    32'd1);
        tick();
        LLIssueE = 1'b0;
        settle();
        chk("ll_busy_pnd", 32'(LLBusyD),    32'd1);
        tick();
        LLValid = 1'b1; LLRd = 5'd7; LLData = 32'h1234_5678;
        settle();
        chk("ll_no_byp",   32'(RFWE),       32'd0);
        tick();
        LLValid = 1'b0;
        settle();
        chk("ll_we",       32'(RFWE),       32'd1);
        chk("ll_a3",       32'(RFA3),       32'd7);
        chk("ll_wd",       RFWD,            32'h1234_5678);
        chk("ll_busy_wr",  32'(LLBusyD),    32'd1);
        tick(); settle();
        chk("ll_busy_clr", 32'(LLBusyD),    32'd0);
        chk("ll_idle",     32'(RFWE),       32'd0);

        // Starvation: pipeline writes x3 every cycle, one queued x9 result
        tick();
        Rs1D = 5'd0;
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h0000_0033;
        LLValid = 1'b1; LLRd = 5'd9; LLData = 32'h0000_0099;
        settle();
        chk("stv_a3_0",    32'(RFA3),       32'd3);
        tick();
        LLValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("stv_pipe_a3", 32'(RFA3),       32'd3);
            chk("stv_nostall", 32'(WbStallReq), 32'd0);
            tick();
        end
        settle();
        chk("stv_stall",   32'(WbStallReq), 32'd1);
        chk("stv_head_a3", 32'(RFA3),       32'd9);
        chk("stv_head_wd", RFWD,            32'h0000_0099);
        tick(); settle();
        chk("stv_release", 32'(WbStallReq), 32'd0);
        chk("stv_resume",  32'(RFA3),       32'd3);

        // FIFO full: x10, x11 fill it, x12 is held off
        tick();
        LLValid = 1'b1; LLRd = 5'd10; LLData = 32'h0000_0010;
        settle();
        chk("ful_rdy10",   32'(LLReady),    32'd1);
        tick();
        LLRd = 5'd11; LLData = 32'h0000_0011;
        settle();
        chk("ful_rdy11",   32'(LLReady),    32'd1);
        tick();
        RegWriteW = 1'b0;
        LLRd = 5'd12; LLData = 32'h0000_0012;
        settle();
        chk("ful_rdy12",   32'(LLReady),    32'd0);
        chk("ful_drain10", 32'(RFA3),       32'd10);
        tick(); settle();
        chk("ful_rdy12b",  32'(LLReady),    32'd1);
        chk("ful_drain11", 32'(RFA3),       32'd11);
        tick();
        LLValid = 1'b0;
        settle();
        chk("ful_drain12", 32'(RFA3),       32'd12);
        chk("ful_wd12",    RFWD,            32'h0000_0012);
        tick(); settle();
        chk("ful_empty",   32'(RFWE),       32'd0);

        // x0 handling
        tick();
        LLValid = 1'b1; LLRd = 5'd0; LLData = 32'h0000_0055;
        LLIssueE = 1'b1; LLRdE = 5'd0;
        settle();
        chk("x0_ready",    32'(LLReady),    32'd1);
        chk("x0_busy",     32'(LLBusyD),    32'd0);
        tick();
        LLValid = 1'b0; LLIssueE = 1'b0;
        settle();
        chk("x0_no_wr",    32'(RFWE),       32'd0);
        tick();
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h0000_0033;
        LLValid = 1'b1; LLRd = 5'd4; LLData = 32'h0000_0044;
        tick();
        LLValid = 1'b0;
        RdW = 5'd0; ResultW = 32'h0000_0077;
        settle();
        chk("x0_slot_we",  32'(RFWE),       32'd1);
        chk("x0_slot_a3",  32'(RFA3),       32'd4);
        chk("x0_slot_wd",  RFWD,            32'h0000_0044);
        tick();
        RegWriteW = 1'b0;
        settle();
        chk("x0_after",    32'(RFWE),       32'd0);

        // Same-register set and clear in one cycle: set wins
        tick();
        LLIssueE = 1'b1; LLRdE = 5'd13;
        tick();
        LLIssueE = 1'b0;
        LLValid = 1'b1; LLRd = 5'd13; LLData = 32'h0000_0013;
        tick();
        LLValid = 1'b0;
        LLIssueE = 1'b1; LLRdE = 5'd13;
        settle();
        chk("sw_head_a3",  32'(RFA3),       32'd13);
        tick();
        LLIssueE = 1'b0; Rs2D = 5'd13;
        settle();
        chk("sw_busy",     32'(LLBusyD),    32'd1);
        Rs2D = 5'd0; RdD = 5'd12;
        #1;
        chk("sw_other",    32'(LLBusyD),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_wp_arbiter.md
# rf_wp_arbiter

Register-file write-port arbiter and long-latency scoreboard for the rv32i pipeline. The in-order writeback stage and a multi-cycle execution unit (divider or similar, with out-of-band completion) share the single RF write port; the in-order writeback stage has priority. Long-latency results queue in a small FIFO and drain into free write slots. A starvation counter forces a one-cycle writeback freeze so that queued results always retire. A 32-entry pending-bit scoreboard tells decode when a source or destination register still awaits a long-latency result.

## Interface
- XLEN, riscv_pkg::XLEN, data width
- DEPTH, 2, long-latency result FIFO entries (≥1)
- STARVE_MAX, 8, consecutive lost arbitration cycles before a forced freeze (≥1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- RegWriteW  in  1  pipeline writeback valid
- RdW  in  5  pipeline destination
- ResultW  in  XLEN  pipeline write data
- LLIssueE  in  1  long-latency op issued this cycle
- LLRdE  in  5  its destination
- LLValid  in  1  long-latency result valid
- LLRd  in  5  result destination
- LLData  in  XLEN  result data
- LLReady  out  1  FIFO can accept
- Rs1D, Rs2D, RdD  in  5 each  decode-stage register fields
- LLBusyD  out  1  decode must stall (RAW/WAW on pending reg)
- WbStallReq  out  1  pipeline must hold W stage this cycle
- RFWE  out  1  RF write enable
- RFA3  out  5  RF write address
- RFWD  out  XLEN  RF write data

## Operation
- Pipeline claim: pipe_wr = RegWriteW && RdW != 0. An x0 write counts as a free slot.
- Grant: if WbStallReq=1, the FIFO head takes the port. Else if pipe_wr, the pipeline takes it. Else if the FIFO is non-empty, the head takes it. Otherwise RFWE=0.
- While WbStallReq=1 the pipeline write is not performed. The pipeline must present identical W-stage values the next cycle.
- FIFO accept: LLValid && LLReady, where LLReady = !full. An accepted entry with LLRd=0 is discarded (never enqueued).
- FIFO order is strict; no bypass. LLData is never written in its arrival cycle.
- Simultaneous enqueue and dequeue are allowed, including when the FIFO is full. LLReady is still computed from the registered full flag.
- Scoreboard set: LLIssueE && LLRdE != 0 sets pending[LLRdE] at the edge.
- Scoreboard clear: a FIFO-head grant clears pending[head.rd] at the edge.
- Same-register set and clear in one cycle: set wins.
- LLBusyD = pending[Rs1D] | pending[Rs2D] | pending[RdD] | (LLIssueE && LLRdE != 0 && LLRdE ∈ {Rs1D, Rs2D, RdD}). Register x0 is never busy.
- Starvation counter: starve_cnt increments each cycle the FIFO is non-empty and the head is not granted, saturating at STARVE_MAX. It resets to 0 on any head grant or when the FIFO is empty.
- WbStallReq = (starve_cnt == STARVE_MAX). It is a decode of a register only, with no combinational input path.
- Reset (rst=0):
  - FIFO empty, pending=0, starve_cnt=0.
  - Outputs: RFWE=0, LLReady=0, LLBusyD=0, WbStallReq=0, RFA3=0, RFWD=0.
  - Inputs are ignored in the reset cycle.
- Reset mid-operation drops queued results and clears all pending bits. Upstream must flush the long-latency unit on the same reset.

## Timing
- Pipeline path: RFWE/RFA3/RFWD are combinational from RegWriteW/RdW/ResultW. Zero added latency.
- Long-latency path: accepted at edge N, earliest RF write in cycle N+1 (FIFO empty, slot free).
- Pending bit visibility: set at edge N, visible on LLBusyD from cycle N+1. The issue-cycle term covers cycle N.
- Bit clears at the edge ending the RF write cycle. LLBusyD drops the following cycle; the RF write-before-read behaviour supplies the data.
- Worst-case head wait: STARVE_MAX cycles plus the single forced-freeze cycle. WbStallReq lasts exactly one cycle per forced drain.
- LLReady first rises in the cycle after rst returns high.

## Structure
- riscv_pkg additions:
  - typedef ll_wb_t {logic [4:0] rd; logic [XLEN-1:0] data;}
  - localparam REG_X0 = 5'd0
- Sub-module: wb_fifo.
  - Parameterised on DEPTH and element type.
  - Synchronous FIFO with push/pop/full/empty flags and registered full flag.
  - Same reset convention as this block.
- Arbitration, scoreboard and starvation counter live in rf_wp_arbiter.

## Test plan
- Reset: hold rst=0 with LLValid=1, LLIssueE=1 → RFWE=0, LLReady=0, LLBusyD=0, nothing enqueued. Release → LLReady=1 next cycle.
- Pipeline pass-through: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF → same cycle RFWE=1, RFA3=5, RFWD=0xDEADBEEF.
- Long-latency round trip: LLIssueE rd=7 → Rs1D=7 gives LLBusyD=1 in the issue cycle and after. LLValid rd=7 data=0x12345678 with pipeline idle → next cycle RFWE=1, RFA3=7. The cycle after that, LLBusyD=0.
- Starvation: pipeline writes rd=3 every cycle, one LL result rd=9 queued → pipeline wins 8 cycles, then WbStallReq=1 for one cycle with RFA3=9. Then starve_cnt=0 and pipeline writes resume.
- FIFO full: pipeline busy, DEPTH=2, three LL results rd=10,11,12 → third sees LLReady=0 and is held. Drain order is 10, 11, 12 with no loss.
- x0 handling: LL result rd=0 is accepted with no RF write and no pending bit set. RegWriteW=1, RdW=0 with a queued head rd=4 → head written that cycle.
